// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: FSM state encoding and default operand width.
// Used by the sequential divider (div2_seq) and shared with the 2-bit multiplier.
package calc_pkg;

    // Default operand width, common to the multiplier and the divider
    localparam int unsigned CALC_WIDTH = 2;

    // Divider FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div2_seq_if.sv
// Start/ready request and valid-pulse result bundle of the sequential divider.
// master: the requester (drives operands), slave: the divider.
interface div2_seq_if
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    modport master (
        output start, a, b,
        input  ready, valid, q, r, dz
    );

    modport slave (
        input  start, a, b,
        output ready, valid, q, r, dz
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference when it does not go negative.
module div_step #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] rs;

    // Trial subtraction; rs is WIDTH+1 bits so the remainder msb shifted out is not lost.
    // rem < b always holds, so rs - b < b fits in WIDTH bits and a WIDTH-bit subtract suffices.
    always_comb begin
        rs       = {rem, msb};
        q_bit    = (rs >= {1'b0, b});
        rem_next = q_bit ? (rs[WIDTH-1:0] - b) : rs[WIDTH-1:0];
    end
endmodule

// File: rtl/div2_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/ready accept,
// one-cycle valid pulse with quotient, remainder and divide-by-zero flag.
// Optional: define DIV2_SEQ_SIGNED_EN for two's-complement operands (truncating division,
// remainder takes the dividend sign). Without it the divider is purely unsigned.
module div2_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    div2_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] dvd_q;   // dividend, consumed msb first
    logic [WIDTH-1:0] dvs_q;   // divisor
    logic [WIDTH-1:0] rem_q;   // partial remainder
    logic [WIDTH-2:0] quo_q;   // quotient bits so far; the last bit comes straight from the step
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dz_q;
    logic             valid_q;
    logic             ready_q;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw;   // unsigned quotient after the current step
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] r_dz;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .msb      (dvd_q[WIDTH-1]),
        .b        (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_raw = {quo_q, q_bit};

`ifdef DIV2_SEQ_SIGNED_EN
    logic a_neg_q;
    logic b_neg_q;

    // Magnitudes feed the unsigned core; the most negative value maps onto itself,
    // which is the correct unsigned magnitude 2**(WIDTH-1).
    always_comb begin
        a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end

    // Sign fix-up: quotient negative on differing signs, remainder follows the dividend.
    // The divide-by-zero remainder rebuilds a from its stored magnitude and sign.
    always_comb begin
        q_fin = (a_neg_q ^ b_neg_q) ? -q_raw : q_raw;
        r_fin = a_neg_q ? -rem_next : rem_next;
        r_dz  = a_neg_q ? -dvd_q : dvd_q;
    end
`else
    // Unsigned: operands and results pass straight through
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        q_fin = q_raw;
        r_fin = rem_next;
        r_dz  = dvd_q;
    end
`endif

    // FSM with datapath registers and registered outputs.
    // Normal results are captured on the last CALC edge so valid rises on entry to DONE.
    // A divide-by-zero enters DONE with valid low and spends one extra DONE cycle raising it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef DIV2_SEQ_SIGNED_EN
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dvd_q   <= a_mag;
                        dvs_q   <= b_mag;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= CntW'(WIDTH);
                        ready_q <= 1'b0;
`ifdef DIV2_SEQ_SIGNED_EN
                        a_neg_q <= bus.a[WIDTH-1];
                        b_neg_q <= bus.b[WIDTH-1];
`endif
                        state_q <= (b_mag == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= q_raw[WIDTH-2:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        q_q     <= q_fin;
                        r_q     <= r_fin;
                        dz_q    <= 1'b0;
                    end
                end
                DONE: begin
                    if (!valid_q) begin
                        // Divide-by-zero result, dividend still unshifted in dvd_q
                        valid_q <= 1'b1;
                        q_q     <= '1;
                        r_q     <= r_dz;
                        dz_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.valid = valid_q;
    assign bus.q     = q_q;
    assign bus.r     = r_q;
    assign bus.dz    = dz_q;
endmodule

// File: tb/tb_div2_seq.sv
// Self-checking bench for div2_seq: reset values, vector table, exhaustive sweep,
// random operations against an arithmetic model, and handshake/reset corner sequences.
module tb_div2_seq;
`ifdef DIV2_SEQ_SIGNED_EN
    localparam int unsigned W = 4;
`else
    localparam int unsigned W = 2;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    div2_seq_if #(.WIDTH(W)) bus ();

    div2_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    // Reference model straight from the arithmetic rules
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
`ifdef DIV2_SEQ_SIGNED_EN
        int sa;
        int sb;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        if (sb == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (sa == -(1 << (W - 1)) && sb == -1) begin
            q = a; r = '0; dz = 1'b0;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
        end
`else
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
`endif
    endtask

    // One complete operation; returns the result and the accept-to-valid latency in edges
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        int k;
        q = '0; r = '0; dz = 1'b0; lat = -1;
        k = 0;
        while (!bus.ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        @(negedge clk);
        bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b;  // post-accept operand changes must be ignored
        for (int i = 1; i <= 4 * int'(W); i++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                lat = i; q = bus.q; r = bus.r; dz = bus.dz;
                check("ready_low_at_valid", int'(bus.ready), 0);
                break;
            end
        end
        if (lat < 0) begin
            check("valid_timeout", 0, 1);
        end else begin
            @(posedge clk); #1;
            check("valid_one_cycle", int'(bus.valid), 0);
            check("ready_after_done", int'(bus.ready), 1);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    initial begin
        vec_t         vecs[$];
        logic [W-1:0] gq, gr, eq, er;
        logic         gdz, edz;
        int           lat, pulses, ready_bad, t0;
        int           vt[2];
        logic [W-1:0] vq[2];
        logic [W-1:0] vr[2];

        n_pass = 0; n_total = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_ready", int'(bus.ready), 1);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_q", int'(bus.q), 0);
        check("reset_r", int'(bus.r), 0);
        check("reset_dz", int'(bus.dz), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef DIV2_SEQ_SIGNED_EN
        vecs.push_back('{a: W'(-7), b: W'(2),  q: W'(-3), r: W'(-1), dz: 1'b0, lat: W});
        vecs.push_back('{a: W'(7),  b: W'(-2), q: W'(-3), r: W'(1),  dz: 1'b0, lat: W});
        vecs.push_back('{a: W'(-8), b: W'(-1), q: W'(-8), r: W'(0),  dz: 1'b0, lat: W});
        vecs.push_back('{a: W'(-5), b: W'(0),  q: W'(-1), r: W'(-5), dz: 1'b1, lat: 1});
        vecs.push_back('{a: W'(6),  b: W'(3),  q: W'(2),  r: W'(0),  dz: 1'b0, lat: W});
`else
        vecs.push_back('{a: W'(3), b: W'(1), q: W'(3), r: W'(0), dz: 1'b0, lat: W});
        vecs.push_back('{a: W'(3), b: W'(2), q: W'(1), r: W'(1), dz: 1'b0, lat: W});
        vecs.push_back('{a: W'(2), b: W'(3), q: W'(0), r: W'(2), dz: 1'b0, lat: W});
        vecs.push_back('{a: W'(2), b: W'(0), q: W'(3), r: W'(2), dz: 1'b1, lat: 1});
        vecs.push_back('{a: W'(3), b: W'(1), q: W'(3), r: W'(0), dz: 1'b0, lat: W});
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, gq, gr, gdz, lat);
            check($sformatf("vec%0d_q", i), int'(gq), int'(vecs[i].q));
            check($sformatf("vec%0d_r", i), int'(gr), int'(vecs[i].r));
            check($sformatf("vec%0d_dz", i), int'(gdz), int'(vecs[i].dz));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Exhaustive sweep, dividend outer loop, divisor inner loop
        for (int ia = 0; ia < (1 << W); ia++) begin
            for (int ib = 0; ib < (1 << W); ib++) begin
                do_op(W'(ia), W'(ib), gq, gr, gdz, lat);
                model(W'(ia), W'(ib), eq, er, edz);
                check($sformatf("sweep_%0d_%0d_q", ia, ib), int'(gq), int'(eq));
                check($sformatf("sweep_%0d_%0d_r", ia, ib), int'(gr), int'(er));
                check($sformatf("sweep_%0d_%0d_dz", ia, ib), int'(gdz), int'(edz));
                check($sformatf("sweep_%0d_%0d_lat", ia, ib), lat, (ib == 0) ? 1 : int'(W));
`ifndef DIV2_SEQ_SIGNED_EN
                if (ib != 0) begin
                    check($sformatf("sweep_%0d_%0d_identity", ia, ib),
                          int'(gq) * ib + int'(gr), ia);
                    check($sformatf("sweep_%0d_%0d_rem_lt_b", ia, ib), int'(int'(gr) < ib), 1);
                end
`endif
            end
        end

        // Random operations
        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, gq, gr, gdz, lat);
            model(ra, rb, eq, er, edz);
            check($sformatf("rand%0d_q", n), int'(gq), int'(eq));
            check($sformatf("rand%0d_r", n), int'(gr), int'(er));
            check($sformatf("rand%0d_dz", n), int'(gdz), int'(edz));
        end

        // Busy rejection: second start during CALC must be dropped
        @(negedge clk);
        bus.a = W'(3); bus.b = W'(2); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_ready_in_calc", int'(bus.ready), 0);
        @(negedge clk);
        bus.a = W'(1); bus.b = W'(1); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulses = 0; ready_bad = 0; gq = '0; gr = '0;
        for (int i = 0; i < 4 * int'(W) + 6; i++) begin
            if (pulses == 0 && bus.ready) ready_bad++;
            @(posedge clk); #1;
            if (bus.valid) begin
                pulses++; gq = bus.q; gr = bus.r;
            end
        end
        model(W'(3), W'(2), eq, er, edz);
        check("busy_pulses", pulses, 1);
        check("busy_ready_low", ready_bad, 0);
        check("busy_q", int'(gq), int'(eq));
        check("busy_r", int'(gr), int'(er));

        // Asynchronous reset one cycle into CALC
        @(negedge clk);
        bus.a = W'(2); bus.b = W'(1); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(bus.ready), 1);
        check("midrst_valid", int'(bus.valid), 0);
        check("midrst_q", int'(bus.q), 0);
        check("midrst_r", int'(bus.r), 0);
        check("midrst_dz", int'(bus.dz), 0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 * int'(W) + 4; i++) begin
            @(posedge clk); #1;
            if (bus.valid) pulses++;
        end
        check("midrst_no_valid", pulses, 0);
        do_op(W'(2), W'(1), gq, gr, gdz, lat);
        check("midrst_fresh_q", int'(gq), 2);
        check("midrst_fresh_r", int'(gr), 0);

        // Back-to-back with start held high; operands switch right after the first accept
        @(negedge clk);
        bus.a = W'(3); bus.b = W'(1); bus.start = 1'b1;
        @(posedge clk); #1;
        t0 = 0;
        bus.a = W'(2); bus.b = W'(2);
        pulses = 0;
        for (int i = 1; i <= 4 * int'(W) + 8 && pulses < 2; i++) begin
            @(posedge clk); #1;
            if (bus.valid) begin
                vt[pulses] = i; vq[pulses] = bus.q; vr[pulses] = bus.r;
                pulses++;
            end
        end
        bus.start = 1'b0;
        check("b2b_pulses", pulses, 2);
        if (pulses == 2) begin
            check("b2b_first_time", vt[0] - t0, int'(W));
            check("b2b_spacing", vt[1] - vt[0], int'(W) + 2);
            model(W'(3), W'(1), eq, er, edz);
            check("b2b_first_q", int'(vq[0]), int'(eq));
            check("b2b_first_r", int'(vr[0]), int'(er));
            model(W'(2), W'(2), eq, er, edz);
            check("b2b_second_q", int'(vq[1]), int'(eq));
            check("b2b_second_r", int'(vr[1]), int'(er));
        end
        repeat (2 * W + 6) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/div2_seq.md
Name: div2_seq

Overview:
- Sequential restoring divider for the calculator datapath. It is the inverse-operation counterpart of the combinational 2-bit multiplier (MULTI2).
- Accepts dividend/divisor with a start/ready handshake and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle valid pulse.
- Feeds the calculator result mux alongside the multiplier.

Parameters:
- WIDTH, 2, operand/quotient/remainder width in bits (legal 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  dividend; sampled at the accept edge.
- b  input  WIDTH  divisor; sampled at the accept edge.
- ready  output  1  high in IDLE only.
- valid  output  1  one-cycle pulse marking a new result.
- q  output  WIDTH  quotient; held until next result.
- r  output  WIDTH  remainder; held until next result.
- dz  output  1  divide-by-zero flag; held with q/r.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous assert, active-low; release is synchronous to clk.
- Reset values:
  - state=IDLE, ready=1, valid=0, q=0, r=0, dz=0.
  - Internal shift registers and the counter are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On start=1, latch a, b, clear the partial remainder and load cnt=WIDTH.
  - If b==0, go to DONE. Otherwise go to CALC.
  - start=0 stays in IDLE.
- CALC, one restoring step per cycle:
  - rs = {rem, dividend_msb}, computed at WIDTH+1 bits.
  - If rs >= {1'b0,b}: rem = rs-b and shift 1 into the quotient. Otherwise rem = rs and shift 0.
  - The dividend shifts left by 1. cnt decrements.
  - Leave for DONE when cnt reaches 0, i.e. after exactly WIDTH CALC cycles.
- DONE:
  - Drive q, r, dz and valid=1 for exactly one cycle, then go to IDLE.
  - ready=0 in DONE.
- Latency, counted from the accept edge E:
  - Normal case: valid is high in the cycle after edge E+WIDTH, i.e. E+WIDTH+1 cycles.
  - Divide-by-zero: valid is high in the cycle after E+1.
- Divide-by-zero result: q = all ones, r = a, dz=1. For a normal result dz=0.
- start while ready=0 (CALC or DONE) is ignored. No queuing, no error.
- a/b changing after acceptance has no effect.
- Arithmetic invariant (unsigned, b≠0): a == q*b + r and r < b.
- Reset asserted mid-CALC or in DONE:
  - Outputs immediately return to reset values.
  - The in-flight operation is discarded. No valid pulse.
- Back-to-back operation: start may be asserted in the first IDLE cycle after DONE. Minimum period is WIDTH+2 cycles.

Optional Feature:
- Macro: DIV2_SEQ_SIGNED_EN.
- Defined:
  - a, b, q and r are two's complement.
  - Operands are converted to magnitudes, the same unsigned core runs, and the result signs are fixed up in DONE.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Overflow case, a = most negative and b = -1: q = a, r = 0, dz=0.
  - Divide-by-zero: q = all ones, r = a, dz=1.
  - Latency is unchanged; the sign fix-up is done in DONE.
- Undefined: pure unsigned behaviour as specified above. No sign logic is synthesized.

Decomposition:
- Shared package calc_pkg:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Default WIDTH constant, shared with the multiplier.
- One natural combinational sub-module, div_step:
  - Inputs: rem, dividend msb, b.
  - Outputs: next rem, quotient bit.
  - Instantiated once in CALC.
- The FSM, counter and registers stay in div2_seq.

Test Plan:
- Exhaustive unsigned sweep, WIDTH=2:
  - Cover all 16 (a,b) pairs with the same nested-loop order as the MULTI2 bench.
  - For b≠0, check a==q*b+r and r<b.
  - Spot values: 3/1 -> q=3, r=0; 3/2 -> q=1, r=1; 2/3 -> q=0, r=2.
  - valid is exactly 1 cycle at E+3.
- Divide by zero: a=2, b=0 -> q=2'b11, r=2, dz=1, valid at E+2. The next op 3/1 clears dz to 0.
- Busy rejection: start 3/2, then pulse start with 1/1 during CALC -> only one valid pulse, with q=1, r=1. ready=0 throughout CALC/DONE.
- Reset mid-operation: deassert rst_n asynchronously one cycle into CALC.
  - Outputs must be 0 and ready=1 without waiting for a clock edge.
  - No valid pulse follows.
  - A fresh 2/1 afterwards gives q=2, r=0.
- Back-to-back: issue 3/1 then 2/2 with start held high -> two valid pulses 4 cycles apart (WIDTH+2), results (3,0) then (1,0).
- With DIV2_SEQ_SIGNED_EN and WIDTH=4:
  - -7/2 -> q=4'b1101 (-3), r=4'b1111 (-1).
  - 7/-2 -> q=-3, r=1.
  - -8/-1 -> q=4'b1000, r=0, dz=0.
